// File: rtl/core_pkg.sv
// core_pkg: definitions shared by the fetch stage and its neighbours.
//   XLEN     - address/instruction width
//   RESET_PC - default PC loaded on reset
//   NOP      - canonical no-op encoding (addi x0, x0, 0)
//   fetch_state_e - fetch sequencer states
//   ifid_t   - contents of the IF/ID pipeline register
package core_pkg;

  localparam int              XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;
  localparam logic [XLEN-1:0] NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // one bubble cycle after reset
    ST_RUN   = 2'd1,  // issuing fetches
    ST_HALT  = 2'd2,  // halt_i held, no new fetches
    ST_FAULT = 2'd3   // bad PC seen, waiting for a good redirect
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            valid;
  } ifid_t;

endpackage

// File: rtl/pc_gen.sv
// pc_gen: program counter for the fetch stage.
//   Holds the PC, steps it by 4 on every issued fetch, loads a redirect
//   target, and classifies addresses against the instruction memory
//   (misaligned or word index >= DEPTH is "bad").
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   step_i         a fetch was issued this cycle: pc <= pc + 4
//   load_i         redirect: pc <= load_pc_i (wins over step_i)
//   load_pc_i      redirect target
//   pc_o           current PC
//   pc_bad_o       current PC cannot be fetched
//   load_bad_o     load_pc_i cannot be fetched
module pc_gen #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 256
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            step_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] load_pc_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_bad_o,
  output logic            load_bad_o
);

  // First byte address past the end of instruction memory; comparing the
  // byte address against it is the same as comparing the word index to DEPTH.
  localparam logic [XLEN-1:0] LIMIT = XLEN'(DEPTH) << 2;

  logic [XLEN-1:0] pc_q;

  function automatic logic addr_bad(input logic [XLEN-1:0] addr);
    return (addr[1:0] != 2'b00) || (addr >= LIMIT);
  endfunction

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else if (load_i) begin
      pc_q <= load_pc_i;
    end else if (step_i) begin
      pc_q <= pc_q + XLEN'(4);  // wraps mod 2^XLEN
    end
  end

  assign pc_o       = pc_q;
  assign pc_bad_o   = addr_bad(pc_q);
  assign load_bad_o = addr_bad(load_pc_i);

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage, requester side of instruction_memory.
//   Drives imem_addr_o/imem_en_o from the PC, captures the same-cycle
//   imem_instr_i into a valid/ready IF/ID register, and handles stall,
//   redirect with flush, halt and fetch faults.
// Optional feature: define IFETCH_PERF_EN to add fetch_count_o, a wrapping
//   count of valid_o && ready_i handshakes.
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   imem_addr_o     byte address to instruction memory (always the PC)
//   imem_en_o       fetch issued this cycle
//   imem_instr_i    instruction read combinationally from memory
//   instr_o, pc_o   IF/ID register contents, qualified by valid_o
//   ready_i         decode accepts when valid_o && ready_i
//   redirect_i      taken branch/jump: flush and load redirect_pc_i
//   redirect_pc_i   redirect target byte address
//   halt_i          stop issuing fetches while high
//   fetch_count_o   handshake counter (IFETCH_PERF_EN only)
//   fault_o         sticky fetch fault (misaligned or out of range)
module instr_fetch #(
  parameter int              XLEN     = core_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = core_pkg::RESET_PC,
  parameter int              DEPTH    = 256
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic [XLEN-1:0] imem_addr_o,
  output logic            imem_en_o,
  input  logic [XLEN-1:0] imem_instr_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            valid_o,
  input  logic            ready_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            halt_i,
`ifdef IFETCH_PERF_EN
  output logic [31:0]     fetch_count_o,
`endif
  output logic            fault_o
);

  import core_pkg::*;

  fetch_state_e    state_q, state_d;
  ifid_t           ifid_q;
  logic [XLEN-1:0] pc;
  logic            pc_bad;
  logic            redirect_bad;
  logic            redirect_go;
  logic            adv;
  logic            handshake;

  // Redirects are ignored during the post-reset bubble.
  assign redirect_go = redirect_i && (state_q != ST_IDLE);
  assign handshake   = ifid_q.valid && ready_i;

  // Issue a fetch only when running, not being redirected, the output
  // register is free (or being emptied this cycle) and the PC is fetchable.
  assign adv = (state_q == ST_RUN) && !redirect_i
            && (!ifid_q.valid || ready_i) && !pc_bad;

  pc_gen #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) u_pc_gen (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .step_i     (adv),
    .load_i     (redirect_go),
    .load_pc_i  (redirect_pc_i),
    .pc_o       (pc),
    .pc_bad_o   (pc_bad),
    .load_bad_o (redirect_bad)
  );

  // ---------------------------------------------------------------------
  // Fetch sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets its default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE) begin
      state_d = ST_RUN;
    end else if (redirect_i) begin
      // Redirect decides the PC; halt_i still applies once it lands.
      if (redirect_bad) state_d = ST_FAULT;
      else if (halt_i)  state_d = ST_HALT;
      else              state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pc_bad)      state_d = ST_FAULT;
          else if (halt_i) state_d = ST_HALT;
        end
        ST_HALT: begin
          if (!halt_i) state_d = ST_RUN;
        end
        default: ;  // ST_FAULT leaves only through a good redirect
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // IF/ID register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ifid_q <= '0;
    end else if (redirect_go) begin
      ifid_q.valid <= 1'b0;  // flush, even if decode is accepting
    end else if (adv) begin
      ifid_q.instr <= imem_instr_i;
      ifid_q.pc    <= pc;
      ifid_q.valid <= 1'b1;
    end else if (handshake) begin
      ifid_q.valid <= 1'b0;  // drained with nothing behind it
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          fetch_count_q <= '0;
    else if (handshake) fetch_count_q <= fetch_count_q + 32'd1;
  end

  assign fetch_count_o = fetch_count_q;
`endif

  assign imem_addr_o = pc;
  assign imem_en_o   = adv;
  assign instr_o     = ifid_q.instr;
  assign pc_o        = ifid_q.pc;
  assign valid_o     = ifid_q.valid;
  assign fault_o     = (state_q == ST_FAULT);

endmodule
